// File: rtl/sseg_pkg.sv
// Shared types and constants for the shared seven-segment display block.
// Holds the arbiter state encoding and the active-low hex glyph table.
package sseg_pkg;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs, segment order g..a, indexed by nibble value.
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph lookup.
// Output registers live in the parent.
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = GLYPH[nib];

endmodule

// File: rtl/sseg_share_arbiter.sv
// Round-robin req/ack arbiter sharing HEX1:HEX0 between two byte sources,
// holding each grant for a minimum display time.
module sseg_share_arbiter
    import sseg_pkg::*;
#(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int CNT_W       = 25,
    parameter bit BLANK_IDLE  = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       owner,
    output logic       busy,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             rr_pri;
    logic [7:0]       byte_q;
    logic             elig0, elig1;
    logic             own_req, other_req;
    logic             grant, gidx, reload;
    logic [6:0]       seg_lo, seg_hi;

    // A request seen in the same cycle as its own ack is the old one.
    assign elig0     = req0 & ~ack0;
    assign elig1     = req1 & ~ack1;
    assign own_req   = owner ? elig1 : elig0;
    assign other_req = owner ? elig0 : elig1;
    assign busy      = (state == HOLD);

    // Next-state, grant selection and hold counter.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        grant   = 1'b0;
        gidx    = owner;
        reload  = 1'b0;
        unique case (state)
            IDLE: begin
                if (elig0 | elig1) begin
                    grant   = 1'b1;
                    gidx    = (elig0 & elig1) ? rr_pri : elig1;
                    reload  = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    if (other_req | own_req) begin
                        grant  = 1'b1;
                        gidx   = other_req ? ~owner : owner;
                        reload = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                    if (own_req) begin
                        grant = 1'b1;
                        gidx  = owner;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (reload) begin
            cnt_n = CNT_LOAD;
        end
    end

    // Arbiter state, latched byte and ack pulses.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            owner  <= 1'b0;
            rr_pri <= 1'b0;
            byte_q <= 8'h00;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ack0  <= grant & ~gidx;
            ack1  <= grant & gidx;
            if (grant) begin
                owner  <= gidx;
                rr_pri <= ~gidx;
                byte_q <= gidx ? data1 : data0;
            end
        end
    end

    sseg_hex_decode u_dec_lo (
        .nib (byte_q[3:0]),
        .seg (seg_lo)
    );

    sseg_hex_decode u_dec_hi (
        .nib (byte_q[7:4]),
        .seg (seg_hi)
    );

    // Registered glyph outputs, blanked while idle when configured.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            HEX0 <= SEG_BLANK;
            HEX1 <= SEG_BLANK;
        end else if (BLANK_IDLE && state == IDLE) begin
            HEX0 <= SEG_BLANK;
            HEX1 <= SEG_BLANK;
        end else begin
            HEX0 <= seg_lo;
            HEX1 <= seg_hi;
        end
    end

endmodule

// File: tb/tb_sseg_share_arbiter.sv
// Scoreboard bench for sseg_share_arbiter with HOLD_CYCLES=4.
// Stimulus queues expected acks; a negedge monitor checks them and HEX.
module tb_sseg_share_arbiter;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       ack0, ack1, owner, busy;
    logic [6:0] HEX0, HEX1;

    sseg_share_arbiter #(
        .HOLD_CYCLES (4),
        .CNT_W       (3),
        .BLANK_IDLE  (1'b1)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .req0     (req0),
        .data0    (data0),
        .ack0     (ack0),
        .req1     (req1),
        .data1    (data1),
        .ack1     (ack1),
        .owner    (owner),
        .busy     (busy),
        .HEX0     (HEX0),
        .HEX1     (HEX1)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         src;
        logic [7:0] data;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          auto0 = 0;
    int          auto1 = 0;
    logic        hex_pend;
    logic [13:0] hex_exp;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b0100111;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [13:0] hexpair(input logic [7:0] b);
        return {glyph(b[7:4]), glyph(b[3:0])};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic expect_ack(input int c, input bit s, input logic [7:0] d);
        exp_t e;
        e.cyc  = c;
        e.src  = s;
        e.data = d;
        q.push_back(e);
    endtask

    // One clock; requesters drop req after seeing ack and optionally
    // re-raise on the following cycle with fresh data.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        if (ack0) begin
            req0 = 1'b0;
        end else if (!req0 && auto0 > 0) begin
            auto0--;
            data0 = data0 + 8'h11;
            req0  = 1'b1;
        end
        if (ack1) begin
            req1 = 1'b0;
        end else if (!req1 && auto1 > 0) begin
            auto1--;
            data1 = data1 + 8'h11;
            req1  = 1'b1;
        end
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hex0"}, 32'(HEX0), 32'h7F);
        chk({tag, "_hex1"}, 32'(HEX1), 32'h7F);
        chk({tag, "_ack"}, {30'b0, ack1, ack0}, 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_owner"}, 32'(owner), 32'h0);
    endtask

    // Monitor: pops an expectation for every ack pulse, then checks
    // the glyphs one edge later.
    initial begin
        exp_t e;
        hex_pend = 1'b0;
        hex_exp  = '0;
        forever begin
            @(negedge CLOCK_50);
            if (hex_pend) begin
                chk("hex_pair", {18'b0, HEX1, HEX0}, {18'b0, hex_exp});
                hex_pend = 1'b0;
            end
            if (ack0 || ack1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL ack_unexpected: ack0=%0d ack1=%0d cycle %0d, none expected",
                             ack0, ack1, cyc);
                end else begin
                    e = q.pop_front();
                    chk("ack_cycle", cyc, e.cyc);
                    chk("ack_src", {30'b0, ack1, ack0},
                        e.src ? 32'h2 : 32'h1);
                    chk("owner_at_ack", 32'(owner), 32'(e.src));
                    hex_exp  = hexpair(e.data);
                    hex_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = 8'h00;
        data1 = 8'h00;

        // Reset takes effect before any clock edge.
        #2 reset = 1'b1;
        #1 chk_reset_vals("rst_init");
        tick();
        tick();
        #2 reset = 1'b0;
        tick();

        // Single request from source 0.
        req0  = 1'b1;
        data0 = 8'h3A;
        expect_ack(cyc + 1, 1'b0, 8'h3A);
        tick();
        chk("t2_busy_n1", 32'(busy), 32'h1);
        chk("t2_owner", 32'(owner), 32'h0);
        tick();
        tick();
        tick();
        chk("t2_busy_n4", 32'(busy), 32'h1);
        tick();
        chk("t2_busy_n5", 32'(busy), 32'h0);
        chk("t2_hex_n5", {18'b0, HEX1, HEX0}, {18'b0, hexpair(8'h3A)});
        tick();
        chk("t2_blank", {18'b0, HEX1, HEX0}, 32'h3FFF);

        // Simultaneous requests after reset: 0 first, then 1 with no gap.
        pulse_reset();
        tick();
        req0  = 1'b1;
        data0 = 8'h12;
        req1  = 1'b1;
        data1 = 8'hEF;
        expect_ack(cyc + 1, 1'b0, 8'h12);
        expect_ack(cyc + 5, 1'b1, 8'hEF);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 4) chk("t3_busy_n4", 32'(busy), 32'h1);
            if (i == 5) chk("t3_busy_n5", 32'(busy), 32'h1);
            if (i == 5) chk("t3_owner_n5", 32'(owner), 32'h1);
            if (i == 9) chk("t3_busy_n9", 32'(busy), 32'h0);
            if (i == 10) chk("t3_blank", {18'b0, HEX1, HEX0}, 32'h3FFF);
        end

        // Owner update mid-hold keeps the original expiry.
        req0  = 1'b1;
        data0 = 8'hC4;
        expect_ack(cyc + 1, 1'b0, 8'hC4);
        tick();
        tick();
        tick();
        req0  = 1'b1;
        data0 = 8'h5F;
        expect_ack(cyc + 1, 1'b0, 8'h5F);
        tick();
        chk("t4_busy_g3", 32'(busy), 32'h1);
        tick();
        chk("t4_busy_g4", 32'(busy), 32'h0);
        tick();
        chk("t4_blank", {18'b0, HEX1, HEX0}, 32'h3FFF);

        // Both sources keep re-requesting: grants alternate 0,1,0,1.
        pulse_reset();
        tick();
        data0 = 8'h20;
        data1 = 8'hA0;
        req0  = 1'b1;
        req1  = 1'b1;
        auto0 = 3;
        auto1 = 3;
        expect_ack(cyc + 1,  1'b0, 8'h20);
        expect_ack(cyc + 3,  1'b0, 8'h31);
        expect_ack(cyc + 5,  1'b1, 8'hA0);
        expect_ack(cyc + 7,  1'b1, 8'hB1);
        expect_ack(cyc + 9,  1'b0, 8'h42);
        expect_ack(cyc + 11, 1'b0, 8'h53);
        expect_ack(cyc + 13, 1'b1, 8'hC2);
        expect_ack(cyc + 15, 1'b1, 8'hD3);
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 4)  chk("t5_owner_n4", 32'(owner), 32'h0);
            if (i == 8)  chk("t5_owner_n8", 32'(owner), 32'h1);
            if (i == 9)  chk("t5_busy_n9", 32'(busy), 32'h1);
            if (i == 16) chk("t5_busy_n16", 32'(busy), 32'h1);
            if (i == 17) chk("t5_busy_n17", 32'(busy), 32'h0);
        end

        // Reset during a source-1 hold with source 0 pending.
        pulse_reset();
        tick();
        req1  = 1'b1;
        data1 = 8'h96;
        expect_ack(cyc + 1, 1'b1, 8'h96);
        tick();
        req0  = 1'b1;
        data0 = 8'h7D;
        tick();
        tick();
        chk("t6_busy_pre", 32'(busy), 32'h1);
        chk("t6_owner_pre", 32'(owner), 32'h1);
        #2 reset = 1'b1;
        #1 chk_reset_vals("t6_rst");
        #3 reset = 1'b0;
        expect_ack(cyc + 1, 1'b0, 8'h7D);
        for (int i = 1; i <= 7; i++) tick();
        chk("t6_busy_end", 32'(busy), 32'h0);

        chk("queue_empty", q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sseg_share_arbiter.md
Name: sseg_share_arbiter

Overview:
- Shares the two-digit seven-segment display (HEX1:HEX0) between two independent 8-bit requesters, e.g. the Nios II ssegs PIO and a hardware debug source.
- Arbitrates with a req/ack handshake and round-robin priority. Each grant is held for a minimum display time so values stay readable.
- Latches the granted byte and drives registered, active-low hex glyphs to the board digits.
- Sits between the Nios system export and the HEX pins, replacing direct combinational decoding.

Parameters:
- HOLD_CYCLES, 25_000_000: minimum cycles a granted value stays displayed (0.5 s at 50 MHz). Legal minimum is 1.
- CNT_W, 25: hold counter width. Must satisfy 2**CNT_W > HOLD_CYCLES.
- BLANK_IDLE, 1: 1 = blank both digits when no grant is active; 0 = keep showing the last value.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  source 0 request, level; held until ack0.
- data0  in  8  source 0 byte; must be stable while req0=1.
- ack0  out  1  one-cycle pulse: data0 has been latched.
- req1  in  1  source 1 request.
- data1  in  8  source 1 byte.
- ack1  out  1  one-cycle pulse: data1 has been latched.
- owner  out  1  index of the current or last granted source.
- busy  out  1  1 while in HOLD.
- HEX0  out  7  active-low segments, low nibble of the latched byte.
- HEX1  out  7  active-low segments, high nibble of the latched byte.

Behaviour:
- Reset values (async, while reset=1): state=IDLE, ack0=ack1=0, owner=0, busy=0, latched byte=8'h00, counter=0, rr_pri=0, HEX0=HEX1=7'h7F (blank). Reset is effective immediately, including mid-HOLD. After release, pending requests are arbitrated normally.
- Handshake:
  - A source's req is ignored in any cycle where its own ack is 1.
  - The requester drops req on the edge after it sees ack. Holding req longer is treated as a new request.
- Grant selection:
  - If only one source requests, it wins.
  - If both request, the rr_pri source wins.
  - After every grant, rr_pri = NOT granted index.
- States:
  - IDLE: busy=0. On any eligible req at edge N:
    - At edge N+1: latch the winner's data, pulse its ack, set owner, load counter=HOLD_CYCLES-1, enter HOLD.
  - HOLD: busy=1, counter decrements by 1 per cycle.
    - Owner re-request: latch new data and pulse ack. The counter is NOT reloaded, so the hold end is unchanged.
    - Non-owner request: waits, no ack.
  - At the HOLD cycle with counter==0:
    - If the non-owner is requesting, grant it on the next edge: latch, ack, reload counter, stay in HOLD. There is no IDLE gap.
    - Otherwise, if the owner is requesting, re-grant the owner the same way.
    - Otherwise go to IDLE.
    - An owner update and expiry in the same cycle resolve as expiry arbitration (round-robin applies).
- Display:
  - HEX0/HEX1 are registered from the decoded latched byte, so they update one edge after the latch (edge N+2 relative to req sampling).
  - In IDLE with BLANK_IDLE=1, both digits = 7'h7F on the edge after entering IDLE.
- Glyph table (active-low, segment order g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - c=0100111, d=0100001, E=0000110, F=0001110
- Counter: unsigned, never wraps, because it is only decremented while >0.

Decomposition:
- Package sseg_pkg contains:
  - state enum {IDLE, HOLD}
  - SEG_BLANK = 7'h7F
  - the 16-entry glyph constant table
- Sub-module sseg_hex_decode: combinational 4-bit nibble to 7-bit glyph. Instantiated twice; the output registers live in the parent.

Test Plan (HOLD_CYCLES=4, BLANK_IDLE=1):
1. Reset pulse mid-stream -> HEX0=HEX1=7'h7F, ack0=ack1=0, busy=0, owner=0, asynchronously with no clock edge needed.
2. req0=1, data0=8'h3A at edge N -> ack0=1 at N+1 only, owner=0, busy=1 from N+1. At N+2, HEX1=0110000 and HEX0=0001000. HOLD lasts 4 cycles, then IDLE and blank.
3. req0 and req1 both rise at edge N after reset (data 8'h12 / 8'hEF) -> ack0 at N+1. ack1 at N+5 with no IDLE cycle. HEX shows 12, then E F (0000110/0001110).
4. Owner update: during source-0 HOLD, req0 with 8'h5F two cycles after grant -> ack0 pulse, HEX shows 5F, busy still falls at the original expiry cycle.
5. req0 and req1 held continuously and re-asserted after each ack -> grants alternate 0,1,0,1 every 4 cycles; owner toggles accordingly.
6. Reset asserted during a source-1 HOLD while req0 is pending -> immediate reset values. After release, ack0 arrives one edge after the first sampled req0.
